// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: write/read requests, data, status and error flags.
// The master drives requests and write data; the slave (the FIFO) drives everything else.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic [DATA_W-1:0] wdata;
    logic              winc;
    logic              rinc;
    logic              wfull;
    logic              walmost_full;
    logic              rempty;
    logic              ralmost_empty;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wdata, winc, rinc,
        input  wfull, walmost_full, rempty, ralmost_empty,
        input  rdata, rvalid, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc,
        output wfull, walmost_full, rempty, ralmost_empty,
        output rdata, rvalid, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AFULL_TH  = 12,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clr,
    sync_fifo_param_if.slave     bus
);
    localparam int unsigned     DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W:0]   cnt;
    logic              full;
    logic              empty;
    logic              wen;
    logic              ren;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              overflow_q;
    logic              underflow_q;

    // Extra pointer MSB is the wrap bit; modular subtraction gives occupancy directly.
    assign cnt   = wptr - rptr;
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty = (wptr == rptr);

    assign wen = bus.winc && !full  && !clr;
    assign ren = bus.rinc && !empty && !clr;

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wptr[ADDR_W-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr        <= '0;
            rptr        <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            // Flush leaves rdata and memory contents untouched.
            wptr        <= '0;
            rptr        <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wen) begin
                wptr <= wptr + PTR_ONE;
            end
            if (ren) begin
                rdata_q <= mem[rptr[ADDR_W-1:0]];
                rptr    <= rptr + PTR_ONE;
            end
            rvalid_q <= ren;
            if (bus.winc && full) begin
                overflow_q <= 1'b1;
            end
            if (bus.rinc && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.wfull         = full;
    assign bus.rempty        = empty;
    assign bus.walmost_full  = (cnt >= AFULL_C);
    assign bus.ralmost_empty = (cnt <= AEMPTY_C);
    assign bus.count         = cnt;
    assign bus.rdata         = rdata_q;
    assign bus.rvalid        = rvalid_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sync_fifo_param;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned AFULL_TH  = 12;
    localparam int unsigned AEMPTY_TH = 2;
    localparam int          DEPTH     = 16;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sync_fifo_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk), .nrst(nrst), .clr(clr), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is a queue, flags follow from its size.
    logic [15:0] q[$];
    logic        m_rvalid = 1'b0;
    logic [15:0] m_rdata  = '0;
    logic        m_ovf    = 1'b0;
    logic        m_unf    = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q.delete();
            m_rvalid = 1'b0;
            m_rdata  = '0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else if (clr) begin
            q.delete();
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_rvalid  = 1'b0;
            if (bus.rinc && !was_empty) begin
                m_rdata  = q.pop_front();
                m_rvalid = 1'b1;
            end
            if (bus.winc && !was_full) q.push_back(bus.wdata);
            if (bus.winc && was_full)  m_ovf = 1'b1;
            if (bus.rinc && was_empty) m_unf = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            chk("cyc_count",   32'(bus.count),         32'(q.size()));
            chk("cyc_wfull",   32'(bus.wfull),         32'(q.size() == DEPTH));
            chk("cyc_afull",   32'(bus.walmost_full),  32'(q.size() >= AFULL_TH));
            chk("cyc_rempty",  32'(bus.rempty),        32'(q.size() == 0));
            chk("cyc_aempty",  32'(bus.ralmost_empty), 32'(q.size() <= AEMPTY_TH));
            chk("cyc_rvalid",  32'(bus.rvalid),        32'(m_rvalid));
            chk("cyc_rdata",   32'(bus.rdata),         32'(m_rdata));
            chk("cyc_ovf",     32'(bus.overflow),      32'(m_ovf));
            chk("cyc_unf",     32'(bus.underflow),     32'(m_unf));
        end
    end

    // Drive one cycle of requests; returns 1 time unit after the edge.
    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        clr       = c;
        @(posedge clk);
        #1;
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = '0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        step(0, 0, 0, 0);
        chk("rst_rempty", 32'(bus.rempty), 1);
        chk("rst_aempty", 32'(bus.ralmost_empty), 1);
        chk("rst_wfull",  32'(bus.wfull), 0);
        chk("rst_afull",  32'(bus.walmost_full), 0);
        chk("rst_count",  32'(bus.count), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_ovf",    32'(bus.overflow), 0);
        chk("rst_unf",    32'(bus.underflow), 0);

        // Fill with 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            step(1, 16'(i), 0, 0);
            chk("fill_count", 32'(bus.count), 32'(i));
            chk("fill_afull", 32'(bus.walmost_full), 32'(i >= 12));
        end
        chk("fill_wfull", 32'(bus.wfull), 1);

        // Overflow attempt
        step(1, 16'hDEAD, 0, 0);
        chk("ovf_flag",  32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 16);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 1, 0);
            chk("drain_rvalid", 32'(bus.rvalid), 1);
            chk("drain_rdata",  32'(bus.rdata), 32'(i));
        end
        chk("drain_rempty", 32'(bus.rempty), 1);
        step(0, 0, 0, 0);
        chk("drain_rvalid_low", 32'(bus.rvalid), 0);
        chk("drain_rdata_hold", 32'(bus.rdata), 32'h10);

        // Underflow attempt
        step(0, 0, 1, 0);
        chk("unf_flag",   32'(bus.underflow), 1);
        chk("unf_rvalid", 32'(bus.rvalid), 0);
        step(0, 0, 0, 1);
        chk("clr_flags", 32'({bus.overflow, bus.underflow}), 0);

        // Simultaneous at count=5
        for (int i = 0; i < 5; i++) step(1, 16'(16'h100 + i), 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(1, 16'(16'h200 + k), 1, 0);
            chk("sim_count", 32'(bus.count), 5);
            chk("sim_rdata", 32'(bus.rdata), (k < 5) ? 32'(32'h100 + k) : 32'(32'h200 + k - 5));
        end
        for (int i = 0; i < 11; i++) step(1, 16'(16'h280 + i), 0, 0);
        chk("sim_full", 32'(bus.wfull), 1);
        step(1, 16'hAAAA, 1, 0);
        chk("simfull_count", 32'(bus.count), 15);
        chk("simfull_ovf",   32'(bus.overflow), 1);
        chk("simfull_rdata", 32'(bus.rdata), 32'h205);
        step(0, 0, 0, 1);
        step(1, 16'h0300, 1, 0);
        chk("simempty_count",  32'(bus.count), 1);
        chk("simempty_unf",    32'(bus.underflow), 1);
        chk("simempty_rvalid", 32'(bus.rvalid), 0);
        step(0, 0, 1, 0);
        chk("simempty_rdata", 32'(bus.rdata), 32'h300);

        // Wrap-around with random gaps
        begin
            int wr_i, rd_i, guard;
            logic w, r;
            wr_i = 0; rd_i = 0; guard = 0;
            while (rd_i < 40 && guard < 2000) begin
                w = (wr_i < 40) && (q.size() < DEPTH) && ($urandom_range(0, 2) != 0);
                r = (q.size() > 0) && ($urandom_range(0, 2) != 0);
                step(w, 16'(16'h400 + wr_i), r, 0);
                if (w) wr_i++;
                if (bus.rvalid) begin
                    chk("wrap_rdata", 32'(bus.rdata), 32'(32'h400 + rd_i));
                    rd_i++;
                end
                guard++;
            end
            chk("wrap_done", 32'(rd_i), 40);
        end

        // Flush at count=9 with overflow set
        for (int i = 0; i < 16; i++) step(1, 16'(16'h500 + i), 0, 0);
        step(1, 16'hDEAD, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0);
            chk("pre_clr_rdata", 32'(bus.rdata), 32'(32'h500 + i));
        end
        chk("pre_clr_count", 32'(bus.count), 9);
        chk("pre_clr_ovf",   32'(bus.overflow), 1);
        step(1, 16'hBEEF, 0, 1);
        chk("clr_count",  32'(bus.count), 0);
        chk("clr_rempty", 32'(bus.rempty), 1);
        chk("clr_ovf",    32'(bus.overflow), 0);
        chk("clr_unf",    32'(bus.underflow), 0);
        chk("clr_rvalid", 32'(bus.rvalid), 0);
        step(0, 0, 0, 0);
        chk("clr_discard", 32'(bus.count), 0);

        // Asynchronous reset during a read
        step(1, 16'h0600, 0, 0);
        step(1, 16'h0601, 0, 0);
        step(0, 0, 1, 0);
        chk("mid_rvalid_pre", 32'(bus.rvalid), 1);
        chk("mid_rdata_pre",  32'(bus.rdata), 32'h600);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rvalid", 32'(bus.rvalid), 0);
        chk("mid_count",  32'(bus.count), 0);
        chk("mid_rempty", 32'(bus.rempty), 1);
        #3 nrst = 1'b1;
        step(0, 0, 0, 0);
        chk("post_rst_count", 32'(bus.count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO.
- Used where producer and consumer share one clock, so no pointer synchronizers are needed.
- Generalised data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Keeps the winc/rinc/wfull/rempty/rdata/rvalid handshake style of the existing FIFO.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W words (default 16).
- AFULL_TH, 12, walmost_full asserts when count >= AFULL_TH; legal range 1..2**ADDR_W.
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH; legal range 0..2**ADDR_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; empties the FIFO and clears error flags.
- wdata  input  DATA_W  write data.
- winc  input  1  write request.
- rinc  input  1  read request.
- wfull  output  1  FIFO holds 2**ADDR_W words.
- walmost_full  output  1  count >= AFULL_TH.
- rempty  output  1  count == 0.
- ralmost_empty  output  1  count <= AEMPTY_TH.
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  rdata valid this cycle.
- count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (nrst low, asynchronous):
  - wptr, rptr, count = 0; rdata = 0; rvalid = 0; overflow = 0; underflow = 0.
  - Resulting flags: rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0 (0 when AFULL_TH >= 1).
- Pointers:
  - wptr and rptr are ADDR_W+1 bits; the extra MSB is the wrap bit.
  - Full: MSBs differ and low bits are equal. Empty: pointers are equal.
  - count = wptr - rptr, computed modulo 2**(ADDR_W+1).
  - All flags are combinational decodes of registered pointers/count, so they reflect operations completed on the previous edge.
- Accept rules, evaluated against current-cycle flags:
  - Write accepted (wen) iff winc && !wfull. The memory word at wptr[ADDR_W-1:0] is written and wptr increments.
  - Read accepted (ren) iff rinc && !rempty. rdata <= mem[rptr[ADDR_W-1:0]] and rptr increments.
  - Read latency is 1 cycle: rvalid is high on the cycle after an accepted read and low otherwise. rdata holds its last value when rvalid is low.
- Simultaneous winc and rinc:
  - Not full and not empty: both accepted; count is unchanged.
  - Full: read accepted, write rejected, overflow set. The write is not retried internally.
  - Empty: write accepted, read rejected, underflow set. No read-through of the incoming word.
- Wrap-around: pointers roll from 2**(ADDR_W+1)-1 to 0 with no special handling; data order is preserved across the wrap.
- Error flags: overflow and underflow are set on a rejected request and stay set until clr or reset.
- clr (synchronous, highest priority over winc/rinc):
  - On the next edge: pointers = 0, rvalid = 0, overflow = 0, underflow = 0.
  - rdata is unchanged and memory contents are not cleared.
  - Requests in the clr cycle are ignored and do not set the error flags.
- Reset mid-operation: asynchronous reset takes effect immediately regardless of in-flight requests; a pending rvalid is lost.
- Memory: a plain register array of 2**ADDR_W x DATA_W, not reset.

Test Plan:
- Reset then idle: nrst low for 3 cycles, release -> rempty=1, ralmost_empty=1, wfull=0, count=0, rvalid=0, overflow=0, underflow=0.
- Fill/drain, defaults: write 0x0001..0x0010 (16 words) -> count=16, wfull=1, walmost_full=1 from count=12. Then read 16 -> rdata 0x0001..0x0010 in order, each with rvalid one cycle after rinc, rempty=1 at the end.
- Overflow and underflow:
  - With FIFO full, winc=1 with wdata=0xDEAD -> overflow=1, count stays 16, 0xDEAD is never read out.
  - On an empty FIFO, rinc=1 -> underflow=1, rvalid stays 0.
- Simultaneous operations:
  - At count=5, winc=rinc=1 for 10 cycles -> count stays 5 and output order is preserved.
  - When full, winc=rinc=1 -> count=15, overflow=1.
  - When empty, winc=rinc=1 -> count=1, underflow=1.
- Wrap-around: run 40 writes and 40 reads interleaved with random gaps, keeping count <= 16 -> all 40 words are read in order, passing the pointer wrap at least twice.
- Flush and mid-operation reset:
  - At count=9 with overflow=1, assert clr with winc=1 -> next cycle count=0, rempty=1, overflow=0, and the write is discarded.
  - Assert nrst low asynchronously during a read -> rvalid drops immediately and count=0.
